// File: rtl/hex_target_issuer.sv
`default_nettype none
// ============================================================================
// Module   : hex_target_issuer
// Purpose  : Issues one non-zero 8-bit hex target per request. Candidates come
//            from the LFSR word. A candidate is rejected if it is zero or if it
//            equals any of the last HIST_DEPTH issued targets. An accepted target
//            is written to TARGET_ADDR over a req/ack write port. It is then
//            fed back on cur_val so the LFSR can avoid it.
// Ports    : clk, rst (async, active-low)
//            rand_in      - LFSR word, low byte used
//            req / clear  - new-target request / flush history and abort
//            mem_wr_*     - write strobe, address, data, acknowledge
//            target, target_valid, cur_val - last accepted target
//            busy, done, err - status and single-cycle completion pulses
//            target_count - accepted-target counter
// Config   : `TARGET_COUNT_EN enables the accepted-target counter; when it is
//            undefined, target_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hex_target_issuer #(
    parameter int                HIST_DEPTH  = 4,
    parameter int                MAX_RETRY   = 8,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] TARGET_ADDR = 16'h00F0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       rand_in,
    input  logic              req,
    input  logic              clear,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [15:0]       mem_wr_data,
    input  logic              mem_wr_ack,
    output logic [7:0]        target,
    output logic              target_valid,
    output logic [15:0]       cur_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       target_count
);

    localparam int c_PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int c_RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SAMPLE = 2'd1;
    localparam logic [1:0] c_ST_CHECK  = 2'd2;
    localparam logic [1:0] c_ST_WRITE  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [7:0]            r_cand;
    logic [c_RTY_W-1:0]    r_retry;
    logic [7:0]            r_hist [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] r_hist_vld;
    logic [c_PTR_W-1:0]    r_wptr;
    logic [7:0]            r_target;
    logic                  r_target_valid;
    logic                  r_done;
    logic                  r_err;

    logic [HIST_DEPTH-1:0] w_match;
    logic                  w_reject;
    logic                  w_retry_last;
    logic                  w_commit;
    logic                  w_give_up;
    logic                  w_unused;

    // Only the low byte of the LFSR word forms a candidate.
    assign w_unused = ^rand_in[15:8];

    // Compare the candidate against every history slot in the same cycle.
    for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist_cmp
        assign w_match[gi] = r_hist_vld[gi] && (r_hist[gi] == r_cand);
    end

    assign w_reject     = (r_cand == 8'h00) || (|w_match);
    assign w_retry_last = (r_retry == c_RTY_W'(MAX_RETRY));

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_give_up   = 1'b0;
        case (r_state)
            c_ST_IDLE:   if (req) w_state_nxt = c_ST_SAMPLE;
            c_ST_SAMPLE: w_state_nxt = c_ST_CHECK;
            c_ST_CHECK: begin
                if (!w_reject) begin
                    w_state_nxt = c_ST_WRITE;
                end else if (w_retry_last) begin
                    w_state_nxt = c_ST_IDLE;
                    w_give_up   = 1'b1;
                end else begin
                    w_state_nxt = c_ST_SAMPLE;
                end
            end
            c_ST_WRITE: begin
                if (mem_wr_ack) begin
                    w_state_nxt = c_ST_IDLE;
                    w_commit    = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        // Clear aborts whatever is in flight without any completion pulse.
        if (clear) begin
            w_state_nxt = c_ST_IDLE;
            w_commit    = 1'b0;
            w_give_up   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand         <= 8'h00;
            r_retry        <= '0;
            r_hist_vld     <= '0;
            r_wptr         <= '0;
            r_target       <= 8'h00;
            r_target_valid <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= 8'h00;
        end else begin
            r_done <= w_commit;
            r_err  <= w_give_up;
            if (r_state == c_ST_IDLE && req) begin
                r_retry <= '0;
            end
            if (r_state == c_ST_SAMPLE && !clear) begin
                r_cand  <= rand_in[7:0];
                r_retry <= r_retry + c_RTY_W'(1);
            end
            if (clear) begin
                r_hist_vld     <= '0;
                r_wptr         <= '0;
                r_target       <= 8'h00;
                r_target_valid <= 1'b0;
            end else if (w_commit) begin
                r_target           <= r_cand;
                r_target_valid     <= 1'b1;
                r_hist[r_wptr]     <= r_cand;
                r_hist_vld[r_wptr] <= 1'b1;
                // Circular buffer: the oldest entry is overwritten on wrap.
                r_wptr <= (r_wptr == c_PTR_W'(HIST_DEPTH - 1)) ? '0 : r_wptr + c_PTR_W'(1);
            end
        end
    end

`ifdef TARGET_COUNT_EN
    logic [15:0] r_target_count;

    // Counts accepted targets; only reset clears it, clear does not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          r_target_count <= 16'h0000;
        else if (w_commit) r_target_count <= r_target_count + 16'h0001;
    end

    assign target_count = r_target_count;
`else
    assign target_count = 16'h0000;
`endif

    // Write port is derived from the state register, so an async reset drops
    // the strobe immediately.
    assign mem_wr_en    = (r_state == c_ST_WRITE);
    assign mem_wr_addr  = mem_wr_en ? TARGET_ADDR : '0;
    assign mem_wr_data  = mem_wr_en ? {8'h00, r_cand} : 16'h0000;
    assign target       = r_target;
    assign target_valid = r_target_valid;
    assign cur_val      = {8'h00, r_target};
    assign busy         = (r_state != c_ST_IDLE);
    assign done         = r_done;
    assign err          = r_err;

endmodule
`default_nettype wire
